// File: rtl/axis_pkg.sv
// axis_pkg: shared AXI4-Stream parameter set plus the types used by the stream arbiters.
package axis_pkg;

   typedef struct packed {
      int DATA_WIDTH;
      int ID_WIDTH;
      int DEST_WIDTH;
      int USER_WIDTH;
   } axis_params_t;

   localparam axis_params_t AXIS_PARAMETERS_DEFAULT = '{
      DATA_WIDTH: 32,
      ID_WIDTH:   4,
      DEST_WIDTH: 4,
      USER_WIDTH: 2
   };

   localparam int AXIS_ARB_MAX_INPUTS = 16;

   typedef enum logic {ARB, LOCK} axis_arb_state_t;

   // Width of an index into n requesters, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/axis_if.sv
// axis_if: AXI4-Stream bundle sized by one axis_params_t parameter set.
interface axis_if #(
   parameter axis_pkg::axis_params_t P = axis_pkg::AXIS_PARAMETERS_DEFAULT
) ();
   logic                      TVALID;
   logic                      TREADY;
   logic                      TLAST;
   logic [P.DATA_WIDTH-1:0]   TDATA;
   logic [P.DATA_WIDTH/8-1:0] TSTRB;
   logic [P.DATA_WIDTH/8-1:0] TKEEP;
   logic [P.ID_WIDTH-1:0]     TID;
   logic [P.DEST_WIDTH-1:0]   TDEST;
   logic [P.USER_WIDTH-1:0]   TUSER;

   modport tx (output TVALID, TLAST, TDATA, TSTRB, TKEEP, TID, TDEST, TUSER, input TREADY);
   modport rx (input TVALID, TLAST, TDATA, TSTRB, TKEEP, TID, TDEST, TUSER, output TREADY);
endinterface

// File: rtl/axis_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector; picks the first request strictly after last_idx.
module rr_pick
   import axis_pkg::*;
#(
   parameter  int NUM_INPUTS = 4,
   localparam int IXW        = idx_width(NUM_INPUTS)
) (
   input  logic [NUM_INPUTS-1:0] req,
   input  logic [IXW-1:0]        last_idx,
   output logic [NUM_INPUTS-1:0] pick,
   output logic [IXW-1:0]        idx,
   output logic                  any
);
   logic [IXW-1:0] j;

   // Scan from lowest to highest priority so the highest-priority hit overwrites the rest.
   always_comb begin
      pick = '0;
      idx  = '0;
      j    = '0;
      for (int k = NUM_INPUTS; k >= 1; k--) begin
         j = IXW'((int'(last_idx) + k) % NUM_INPUTS);
         if (req[j]) begin
            pick    = '0;
            pick[j] = 1'b1;
            idx     = j;
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: packet-granular round-robin merge of NUM_INPUTS AXI4-Stream sources.
// A grant is held from the first beat until the TLAST handshake, so packets never interleave.
module axis_rr_arbiter
   import axis_pkg::*;
#(
   parameter axis_params_t AXIS_PARAMETERS = AXIS_PARAMETERS_DEFAULT,
   parameter int           NUM_INPUTS      = 4,
   parameter bit           TID_FROM_PORT   = 1'b0
) (
   input  logic                  ACLK,
   input  logic                  ARESETn,
   axis_if.rx                    s_axis [NUM_INPUTS],
   axis_if.tx                    m_axis,
   output logic [NUM_INPUTS-1:0] grant,
   output logic                  busy
);
   localparam int DW  = AXIS_PARAMETERS.DATA_WIDTH;
   localparam int KW  = DW / 8;
   localparam int IW  = AXIS_PARAMETERS.ID_WIDTH;
   localparam int DSW = AXIS_PARAMETERS.DEST_WIDTH;
   localparam int UW  = AXIS_PARAMETERS.USER_WIDTH;
   localparam int IXW = idx_width(NUM_INPUTS);

   typedef struct packed {
      logic           tvalid;
      logic           tlast;
      logic [DW-1:0]  tdata;
      logic [KW-1:0]  tstrb;
      logic [KW-1:0]  tkeep;
      logic [IW-1:0]  tid;
      logic [DSW-1:0] tdest;
      logic [UW-1:0]  tuser;
   } beat_t;

   localparam int BW = $bits(beat_t);

   axis_arb_state_t       state;
   logic [IXW-1:0]        last_idx;
   logic [IXW-1:0]        pick_idx;
   logic [NUM_INPUTS-1:0] req;
   logic [NUM_INPUTS-1:0] pick;
   logic                  any;
   logic [BW-1:0]         beat [NUM_INPUTS];
   logic [BW-1:0]         acc;
   beat_t                 sel;

   for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_port
      assign req[i]  = s_axis[i].TVALID;
      assign beat[i] = {s_axis[i].TVALID, s_axis[i].TLAST, s_axis[i].TDATA, s_axis[i].TSTRB,
                        s_axis[i].TKEEP, s_axis[i].TID, s_axis[i].TDEST, s_axis[i].TUSER};
      assign s_axis[i].TREADY = grant[i] & m_axis.TREADY;
   end

   rr_pick #(.NUM_INPUTS(NUM_INPUTS)) u_pick (
      .req      (req),
      .last_idx (last_idx),
      .pick     (pick),
      .idx      (pick_idx),
      .any      (any)
   );

   // AND-OR over the one-hot grant; an empty grant yields an all-zero beat, so TVALID drops in ARB.
   always_comb begin
      acc = '0;
      for (int k = 0; k < NUM_INPUTS; k++) acc = acc | (beat[k] & {BW{grant[k]}});
   end

   assign sel = acc;

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state    <= ARB;
         grant    <= '0;
         last_idx <= IXW'(NUM_INPUTS - 1);
      end else if (state == ARB) begin
         if (any) begin
            state    <= LOCK;
            grant    <= pick;
            last_idx <= pick_idx;
         end
      end else if (sel.tvalid && m_axis.TREADY && sel.tlast) begin
         state <= ARB;
         grant <= '0;
      end
   end

   assign busy          = (state == LOCK);
   assign m_axis.TVALID = sel.tvalid;
   assign m_axis.TLAST  = sel.tlast;
   assign m_axis.TDATA  = sel.tdata;
   assign m_axis.TSTRB  = sel.tstrb;
   assign m_axis.TKEEP  = sel.tkeep;
   assign m_axis.TDEST  = sel.tdest;
   assign m_axis.TUSER  = sel.tuser;
   // last_idx equals the granted index whenever TVALID can be high.
   assign m_axis.TID    = TID_FROM_PORT ? IW'(last_idx) : sel.tid;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb_axis_rr_arbiter: randomized sources checked cycle by cycle against a packet-level
// round-robin model; a second instance with TID_FROM_PORT=1 sees the same stimulus.
module tb_axis_rr_arbiter;
   import axis_pkg::*;

   localparam int           N   = 4;
   localparam axis_params_t P   = AXIS_PARAMETERS_DEFAULT;
   localparam int           DW  = P.DATA_WIDTH;
   localparam int           KW  = DW / 8;
   localparam int           IW  = P.ID_WIDTH;
   localparam int           DSW = P.DEST_WIDTH;
   localparam int           UW  = P.USER_WIDTH;

   logic ACLK = 1'b0;
   logic ARESETn = 1'b0;
   always #5 ACLK = ~ACLK;

   logic           tv   [N];
   logic           tl   [N];
   logic [DW-1:0]  td   [N];
   logic [KW-1:0]  ts   [N];
   logic [KW-1:0]  tk   [N];
   logic [IW-1:0]  tid  [N];
   logic [DSW-1:0] tdst [N];
   logic [UW-1:0]  tu   [N];
   logic           trdy [N];
   logic           trdy2[N];
   logic           m_tready;
   logic [N-1:0]   grant, grant2;
   logic           busy, busy2;

   axis_if #(.P(P)) s_if  [N] ();
   axis_if #(.P(P)) s2_if [N] ();
   axis_if #(.P(P)) m_if ();
   axis_if #(.P(P)) m2_if ();

   for (genvar i = 0; i < N; i++) begin : g_src
      assign s_if[i].TVALID  = tv[i];
      assign s_if[i].TLAST   = tl[i];
      assign s_if[i].TDATA   = td[i];
      assign s_if[i].TSTRB   = ts[i];
      assign s_if[i].TKEEP   = tk[i];
      assign s_if[i].TID     = tid[i];
      assign s_if[i].TDEST   = tdst[i];
      assign s_if[i].TUSER   = tu[i];
      assign s2_if[i].TVALID = tv[i];
      assign s2_if[i].TLAST  = tl[i];
      assign s2_if[i].TDATA  = td[i];
      assign s2_if[i].TSTRB  = ts[i];
      assign s2_if[i].TKEEP  = tk[i];
      assign s2_if[i].TID    = tid[i];
      assign s2_if[i].TDEST  = tdst[i];
      assign s2_if[i].TUSER  = tu[i];
      assign trdy[i]         = s_if[i].TREADY;
      assign trdy2[i]        = s2_if[i].TREADY;
   end

   assign m_if.TREADY  = m_tready;
   assign m2_if.TREADY = m_tready;

   axis_rr_arbiter #(.AXIS_PARAMETERS(P), .NUM_INPUTS(N), .TID_FROM_PORT(1'b0)) dut (
      .ACLK    (ACLK),
      .ARESETn (ARESETn),
      .s_axis  (s_if),
      .m_axis  (m_if),
      .grant   (grant),
      .busy    (busy)
   );

   axis_rr_arbiter #(.AXIS_PARAMETERS(P), .NUM_INPUTS(N), .TID_FROM_PORT(1'b1)) dut2 (
      .ACLK    (ACLK),
      .ARESETn (ARESETn),
      .s_axis  (s2_if),
      .m_axis  (m2_if),
      .grant   (grant2),
      .busy    (busy2)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: owner is the granted requester (-1 = none), last is the previous winner.
   int owner = -1;
   int last  = N - 1;

   // Source state: remaining beats of the current packet, packets still to send, length range,
   // valid probability, and whether the presented beat is accepted at the coming edge.
   int rem  [N];
   int pkts [N];
   int lmin [N];
   int lmax [N];
   int pv   [N];
   bit hs   [N];
   int tr_pct;
   int stall_lo, stall_hi, pcyc;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic clear_sources();
      for (int i = 0; i < N; i++) begin
         tv[i] = 1'b0; tl[i] = 1'b0; td[i] = '0; ts[i] = '0; tk[i] = '0;
         tid[i] = '0; tdst[i] = '0; tu[i] = '0;
         rem[i] = 0; pkts[i] = 0; lmin[i] = 1; lmax[i] = 1; pv[i] = 100; hs[i] = 1'b0;
      end
      tr_pct = 100; stall_lo = 0; stall_hi = 0; pcyc = 0;
   endtask

   task automatic new_beat(input int i);
      tv[i]   = 1'b1;
      tl[i]   = (rem[i] == 1);
      td[i]   = DW'($urandom);
      ts[i]   = KW'($urandom);
      tk[i]   = KW'($urandom);
      tid[i]  = IW'($urandom);
      tdst[i] = DSW'($urandom);
      tu[i]   = UW'($urandom);
   endtask

   // AXI-legal sources: a presented beat is held until accepted; gaps only between beats.
   task automatic drive();
      for (int i = 0; i < N; i++) begin
         if (hs[i]) begin
            rem[i]--;
            tv[i] = 1'b0;
         end
         if (!tv[i]) begin
            if (rem[i] == 0 && pkts[i] > 0) begin
               pkts[i]--;
               rem[i] = int'($urandom_range(lmax[i], lmin[i]));
            end
            if (rem[i] > 0 && int'($urandom_range(99)) < pv[i]) new_beat(i);
         end
         hs[i] = 1'b0;
      end
      m_tready = (pcyc >= stall_lo && pcyc < stall_hi) ? 1'b0 : (int'($urandom_range(99)) < tr_pct);
      pcyc++;
   endtask

   task automatic check_update();
      logic [N-1:0] eg;
      logic         ev, er;
      eg = '0;
      if (owner >= 0) eg[owner] = 1'b1;
      ev = (owner >= 0) && tv[owner];
      chk("grant", 64'(grant), 64'(eg));
      chk("grant2", 64'(grant2), 64'(eg));
      chk("busy", 64'(busy), 64'(owner >= 0));
      chk("busy2", 64'(busy2), 64'(owner >= 0));
      chk("m_tvalid", 64'(m_if.TVALID), 64'(ev));
      chk("m2_tvalid", 64'(m2_if.TVALID), 64'(ev));
      if (ev) begin
         chk("payload", 64'({m_if.TLAST, m_if.TDATA, m_if.TSTRB, m_if.TKEEP, m_if.TID, m_if.TDEST, m_if.TUSER}),
             64'({tl[owner], td[owner], ts[owner], tk[owner], tid[owner], tdst[owner], tu[owner]}));
         chk("payload_tid_port", 64'({m2_if.TLAST, m2_if.TDATA, m2_if.TSTRB, m2_if.TKEEP, m2_if.TID, m2_if.TDEST, m2_if.TUSER}),
             64'({tl[owner], td[owner], ts[owner], tk[owner], IW'(owner), tdst[owner], tu[owner]}));
      end
      for (int i = 0; i < N; i++) begin
         er = (i == owner) && m_tready;
         chk($sformatf("s_tready[%0d]", i), 64'(trdy[i]), 64'(er));
         chk($sformatf("s2_tready[%0d]", i), 64'(trdy2[i]), 64'(er));
         hs[i] = tv[i] && trdy[i];
      end
      if (owner < 0) begin
         for (int k = 1; k <= N; k++)
            if (owner < 0 && tv[(last + k) % N]) begin
               owner = (last + k) % N;
               last  = owner;
            end
      end else if (tv[owner] && m_tready && tl[owner]) begin
         owner = -1;
      end
   endtask

   function automatic bit idle();
      bit b;
      b = (owner < 0);
      for (int i = 0; i < N; i++) b = b && (pkts[i] == 0) && (rem[i] == 0) && !tv[i];
      return b;
   endfunction

   task automatic run(input string tag, input int max_cyc);
      int c;
      c    = 0;
      pcyc = 0;
      do begin
         @(negedge ACLK);
         drive();
         #1;
         check_update();
         c++;
      end while (!idle() && c < max_cyc);
      chk({tag, "_drain"}, 64'(idle()), 64'd1);
   endtask

   initial begin
      int c, beats1;
      clear_sources();
      m_tready = 1'b1;
      for (int i = 0; i < N; i++) begin
         rem[i] = 1;
         new_beat(i);
      end
      // Outputs held at reset values while every input is requesting.
      @(negedge ACLK);
      #1;
      chk("rst_grant", 64'(grant), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_m_tvalid", 64'(m_if.TVALID), 64'd0);
      for (int i = 0; i < N; i++) chk($sformatf("rst_s_tready[%0d]", i), 64'(trdy[i]), 64'd0);
      clear_sources();
      @(negedge ACLK);
      ARESETn = 1'b1;

      // Inputs 0 and 2 each send one 3-beat packet with the sink always ready.
      pkts[0] = 1; pkts[2] = 1;
      lmin[0] = 3; lmax[0] = 3; lmin[2] = 3; lmax[2] = 3;
      run("two_pkts", 40);

      // All inputs stream 1-beat packets continuously.
      clear_sources();
      for (int i = 0; i < N; i++) pkts[i] = 8;
      run("single_beat", 200);

      // Input 1 sends 4 beats, the sink stalls 5 cycles on beat 2, input 3 waits.
      clear_sources();
      pkts[1] = 1; lmin[1] = 4; lmax[1] = 4;
      pkts[3] = 1; lmin[3] = 3; lmax[3] = 3;
      stall_lo = 2; stall_hi = 7;
      run("stall", 60);

      // Input 1 pauses between beats while input 0 keeps requesting.
      clear_sources();
      pkts[0] = 4; lmin[0] = 2; lmax[0] = 2;
      pkts[1] = 2; lmin[1] = 5; lmax[1] = 5; pv[1] = 40;
      run("gap", 400);

      // Fully random traffic, lengths and backpressure.
      clear_sources();
      tr_pct = 60;
      for (int i = 0; i < N; i++) begin
         pkts[i] = 6; lmin[i] = 1; lmax[i] = 6; pv[i] = int'($urandom_range(100, 30));
      end
      run("random", 2000);

      // Reset during beat 3 of a 4-beat packet on input 1.
      clear_sources();
      pkts[1] = 1; lmin[1] = 4; lmax[1] = 4;
      c = 0; beats1 = 0;
      while (beats1 < 2 && c < 50) begin
         @(negedge ACLK);
         drive();
         #1;
         check_update();
         if (hs[1]) beats1++;
         c++;
      end
      chk("reset_setup_beats", 64'(beats1), 64'd2);
      @(posedge ACLK);
      #2;
      chk("pre_rst_busy", 64'(busy), 64'd1);
      chk("pre_rst_m_tvalid", 64'(m_if.TVALID), 64'd1);
      ARESETn = 1'b0;
      #1;
      chk("midrst_grant", 64'(grant), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_m_tvalid", 64'(m_if.TVALID), 64'd0);
      chk("midrst_s1_tready", 64'(trdy[1]), 64'd0);
      clear_sources();
      owner = -1;
      last  = N - 1;
      repeat (2) @(negedge ACLK);
      ARESETn = 1'b1;
      // Inputs 3 and 0 request together; input 0 must win first again.
      pkts[0] = 1; lmin[0] = 2; lmax[0] = 2;
      pkts[3] = 1; lmin[3] = 2; lmax[3] = 2;
      run("post_reset", 40);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
